// File: rtl/num_matrix_loader_pkg.sv
// Shared definitions for the matrix loader: FSM states, error codes and the
// default dimension limit.
package num_matrix_loader_pkg;

  localparam int MAX_DIM_DEFAULT = 5;

  typedef enum logic [2:0] {
    IDLE,
    RD_ROWS,
    RD_COLS,
    CHECK,
    LOAD,
    FINISH,
    ERR
  } state_t;

  typedef enum logic [1:0] {
    ERR_NONE           = 2'b00,
    ERR_SHORT          = 2'b01,
    ERR_BAD_DIM        = 2'b10,
    ERR_COUNT_MISMATCH = 2'b11
  } err_code_t;

  // Element count from the 3-bit dimensions; only meaningful once both are in range.
  function automatic logic [5:0] elem_count(input logic [2:0] rows, input logic [2:0] cols);
    return {3'b000, rows} * {3'b000, cols};
  endfunction

endpackage

// File: rtl/num_matrix_loader_if.sv
// Number-RAM read port plus matrix-store write port of the loader.
interface num_matrix_loader_if #(
  parameter int ADDR_WIDTH = 11,
  parameter int DATA_WIDTH = 32
);

  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  mat_wr_en;
  logic [4:0]            mat_wr_addr;
  logic [DATA_WIDTH-1:0] mat_wr_data;

  modport master (
    output rd_addr,
    output mat_wr_en,
    output mat_wr_addr,
    output mat_wr_data,
    input  rd_data
  );

  modport slave (
    input  rd_addr,
    input  mat_wr_en,
    input  mat_wr_addr,
    input  mat_wr_data,
    output rd_data
  );

endinterface

// File: rtl/num_matrix_loader.sv
// Reads a rows/cols header and row-major elements from the number RAM,
// validates the header, then streams the elements into the matrix store.
module num_matrix_loader
  import num_matrix_loader_pkg::*;
#(
  parameter int ADDR_WIDTH = 11,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_DIM    = MAX_DIM_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [10:0]          num_count,
  num_matrix_loader_if.master  bus,
  output logic [2:0]           mat_rows,
  output logic [2:0]           mat_cols,
  output logic                 busy,
  output logic                 done,
  output logic                 error,
  output err_code_t            err_code
);

  localparam logic signed [DATA_WIDTH-1:0] DIM_MIN = DATA_WIDTH'(1);
  localparam logic signed [DATA_WIDTH-1:0] DIM_MAX = DATA_WIDTH'(MAX_DIM);

  state_t                       state, next_state;
  logic signed [DATA_WIDTH-1:0] rows_raw, cols_raw;
  logic [4:0]                   wr_idx;
  logic [ADDR_WIDTH-1:0]        last_addr, rd_addr_nxt;
  logic                         short_req, dim_bad, count_bad;
  logic                         busy_nxt, done_nxt, error_nxt;
  err_code_t                    err_code_nxt;

  // Header words are judged as full signed values before any truncation.
  assign short_req = num_count < 11'd2;
  assign dim_bad   = (rows_raw < DIM_MIN) || (rows_raw > DIM_MAX) ||
                     (cols_raw < DIM_MIN) || (cols_raw > DIM_MAX);
  assign count_bad = num_count != (11'(elem_count(rows_raw[2:0], cols_raw[2:0])) + 11'd2);
  assign last_addr = ADDR_WIDTH'(elem_count(mat_rows, mat_cols)) + ADDR_WIDTH'(1);

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = short_req ? ERR : RD_ROWS;
      RD_ROWS: next_state = RD_COLS;
      RD_COLS: next_state = CHECK;
      CHECK:   next_state = (dim_bad || count_bad) ? ERR : LOAD;
      LOAD:    if (bus.rd_addr == last_addr) next_state = FINISH;
      FINISH:  next_state = IDLE;
      ERR:     next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    rd_addr_nxt  = bus.rd_addr;
    busy_nxt     = busy;
    done_nxt     = done;
    error_nxt    = error;
    err_code_nxt = err_code;
    case (state)
      IDLE: begin
        if (start) begin
          rd_addr_nxt = '0;
          done_nxt    = 1'b0;
          if (short_req) begin
            busy_nxt     = 1'b0;
            error_nxt    = 1'b1;
            err_code_nxt = ERR_SHORT;
          end else begin
            busy_nxt     = 1'b1;
            error_nxt    = 1'b0;
            err_code_nxt = ERR_NONE;
          end
        end
      end
      RD_ROWS: rd_addr_nxt = ADDR_WIDTH'(1);
      CHECK: begin
        if (dim_bad || count_bad) begin
          busy_nxt     = 1'b0;
          error_nxt    = 1'b1;
          err_code_nxt = dim_bad ? ERR_BAD_DIM : ERR_COUNT_MISMATCH;
        end else begin
          rd_addr_nxt = ADDR_WIDTH'(2);
        end
      end
      LOAD: if (bus.rd_addr != last_addr) rd_addr_nxt = bus.rd_addr + ADDR_WIDTH'(1);
      FINISH: begin
        busy_nxt = 1'b0;
        done_nxt = 1'b1;
      end
      default: ;
    endcase
  end

  // Each LOAD cycle's read word becomes exactly one write on the next cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bus.rd_addr     <= '0;
      bus.mat_wr_en   <= 1'b0;
      bus.mat_wr_addr <= '0;
      bus.mat_wr_data <= '0;
      mat_rows        <= '0;
      mat_cols        <= '0;
      busy            <= 1'b0;
      done            <= 1'b0;
      error           <= 1'b0;
      err_code        <= ERR_NONE;
      rows_raw        <= '0;
      cols_raw        <= '0;
      wr_idx          <= '0;
    end else begin
      bus.rd_addr   <= rd_addr_nxt;
      busy          <= busy_nxt;
      done          <= done_nxt;
      error         <= error_nxt;
      err_code      <= err_code_nxt;
      bus.mat_wr_en <= (state == LOAD);
      if (state == RD_ROWS) rows_raw <= bus.rd_data;
      if (state == RD_COLS) cols_raw <= bus.rd_data;
      if (state == CHECK && next_state == LOAD) begin
        mat_rows <= rows_raw[2:0];
        mat_cols <= cols_raw[2:0];
        wr_idx   <= '0;
      end
      if (state == LOAD) begin
        bus.mat_wr_addr <= wr_idx;
        bus.mat_wr_data <= bus.rd_data;
        wr_idx          <= wr_idx + 5'd1;
      end
    end
  end

endmodule

// File: tb/tb_num_matrix_loader.sv
// Directed bench for num_matrix_loader: a cycle-timed expectation model is
// planned from the RAM contents at each start and compared every cycle.
module tb_num_matrix_loader;

  localparam int AW = 11;
  localparam int DW = 32;

  typedef struct packed {
    logic       busy;
    logic       done;
    logic       error;
    logic [1:0] code;
    logic [2:0] rows;
    logic [2:0] cols;
  } status_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [10:0] num_count;
  logic [2:0]  mat_rows, mat_cols;
  logic        busy, done, error;
  logic [1:0]  err_code;

  logic [31:0] mem [0:63];
  int          cyc = 0;
  int          tests = 0;
  int          fails = 0;
  bit          checking = 1'b0;

  status_t     st_change [int];
  logic [4:0]  exp_waddr [int];
  logic [31:0] exp_wdata [int];
  status_t     plan_st;
  int          wr_cycles [$];
  logic [31:0] wr_log [$];

  num_matrix_loader_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  num_matrix_loader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_DIM(5)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .num_count (num_count),
    .bus       (bus.master),
    .mat_rows  (mat_rows),
    .mat_cols  (mat_cols),
    .busy      (busy),
    .done      (done),
    .error     (error),
    .err_code  (err_code)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Number RAM: the word for a registered address is visible in the following cycle.
  always_comb bus.rd_data = (bus.rd_addr < 11'd64) ? mem[bus.rd_addr[5:0]] : 32'd0;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Expected behaviour of one accepted start issued in cycle s.
  task automatic plan(input int s, input int nc);
    status_t st;
    int r, c;
    st = plan_st;
    st.done = 1'b0;
    if (nc < 2) begin
      st.busy = 1'b0; st.error = 1'b1; st.code = 2'b01;
      st_change[s + 1] = st;
    end else begin
      st.busy = 1'b1; st.error = 1'b0; st.code = 2'b00;
      st_change[s + 1] = st;
      r = $signed(mem[0]);
      c = $signed(mem[1]);
      if (r < 1 || r > 5 || c < 1 || c > 5) begin
        st.busy = 1'b0; st.error = 1'b1; st.code = 2'b10;
        st_change[s + 4] = st;
      end else if (nc != 2 + r * c) begin
        st.busy = 1'b0; st.error = 1'b1; st.code = 2'b11;
        st_change[s + 4] = st;
      end else begin
        st.rows = 3'(r); st.cols = 3'(c);
        st_change[s + 4] = st;
        for (int k = 0; k < r * c; k++) begin
          exp_waddr[s + 5 + k] = 5'(k);
          exp_wdata[s + 5 + k] = mem[2 + k];
        end
        st.busy = 1'b0; st.done = 1'b1;
        st_change[s + 5 + r * c] = st;
      end
    end
    plan_st = st;
  endtask

  task automatic purge(input int from);
    int keys[$];
    foreach (st_change[k]) if (k >= from) keys.push_back(k);
    foreach (exp_waddr[k]) if (k >= from) keys.push_back(k);
    foreach (keys[i]) begin
      st_change.delete(keys[i]);
      exp_waddr.delete(keys[i]);
      exp_wdata.delete(keys[i]);
    end
  endtask

  task automatic compare_loop();
    status_t exp_st;
    exp_st = '0;
    forever begin
      @(negedge clk);
      if (checking) begin
        if (st_change.exists(cyc)) exp_st = st_change[cyc];
        check_output("busy",     32'(busy),     32'(exp_st.busy));
        check_output("done",     32'(done),     32'(exp_st.done));
        check_output("error",    32'(error),    32'(exp_st.error));
        check_output("err_code", 32'(err_code), 32'(exp_st.code));
        check_output("mat_rows", 32'(mat_rows), 32'(exp_st.rows));
        check_output("mat_cols", 32'(mat_cols), 32'(exp_st.cols));
        if (exp_waddr.exists(cyc)) begin
          check_output("wr_en",   32'(bus.mat_wr_en),   32'd1);
          check_output("wr_addr", 32'(bus.mat_wr_addr), 32'(exp_waddr[cyc]));
          check_output("wr_data", bus.mat_wr_data,      exp_wdata[cyc]);
        end else begin
          check_output("wr_en_idle", 32'(bus.mat_wr_en), 32'd0);
        end
        if (bus.mat_wr_en) begin
          wr_cycles.push_back(cyc);
          wr_log.push_back(bus.mat_wr_data);
        end
      end
    end
  endtask

  task automatic apply_stimulus(input int nc, input int len, output int s);
    num_count = 11'(nc);
    start = 1'b1;
    s = cyc;
    plan(s, nc);
    @(negedge clk);
    start = 1'b0;
    repeat (len - 1) @(negedge clk);
  endtask

  task automatic check_reset_values(input string tag);
    check_output({tag, "_rd_addr"},  32'(bus.rd_addr),     32'd0);
    check_output({tag, "_wr_en"},    32'(bus.mat_wr_en),   32'd0);
    check_output({tag, "_wr_addr"},  32'(bus.mat_wr_addr), 32'd0);
    check_output({tag, "_wr_data"},  bus.mat_wr_data,      32'd0);
    check_output({tag, "_rows"},     32'(mat_rows),        32'd0);
    check_output({tag, "_cols"},     32'(mat_cols),        32'd0);
    check_output({tag, "_busy"},     32'(busy),            32'd0);
    check_output({tag, "_done"},     32'(done),            32'd0);
    check_output({tag, "_error"},    32'(error),           32'd0);
    check_output({tag, "_err_code"}, 32'(err_code),        32'd0);
  endtask

  initial begin
    int s, base;
    rst_n = 1'b0;
    start = 1'b0;
    num_count = '0;
    plan_st = '0;
    foreach (mem[i]) mem[i] = 32'd0;
    fork
      compare_loop();
    join_none
    repeat (3) @(negedge clk);
    check_reset_values("reset");
    rst_n = 1'b1;
    checking = 1'b1;
    @(negedge clk);

    // 2x3 matrix, 1..6
    mem[0] = 32'd2; mem[1] = 32'd3;
    for (int k = 0; k < 6; k++) mem[2 + k] = 32'(k + 1);
    base = wr_cycles.size();
    apply_stimulus(8, 11, s);
    check_output("a_writes",      32'(wr_cycles.size() - base), 32'd6);
    check_output("a_first_lat",   32'(wr_cycles[base] - s),     32'd5);
    check_output("a_last_data",   wr_log[wr_log.size() - 1],    32'd6);
    check_output("a_done",        32'(done),                    32'd1);
    check_output("a_rows",        32'(mat_rows),                32'd2);
    check_output("a_cols",        32'(mat_cols),                32'd3);

    // rows=6 is out of range, started in the done cycle
    mem[0] = 32'd6; mem[1] = 32'd1;
    base = wr_cycles.size();
    apply_stimulus(8, 6, s);
    check_output("b_writes",   32'(wr_cycles.size() - base), 32'd0);
    check_output("b_error",    32'(error),                   32'd1);
    check_output("b_err_code", 32'(err_code),                32'd2);
    check_output("b_rows_kept", 32'(mat_rows),               32'd2);
    check_output("b_done",     32'(done),                    32'd0);

    // 2x2 header but only three elements
    mem[0] = 32'd2; mem[1] = 32'd2; mem[2] = 32'd7; mem[3] = 32'd8; mem[4] = 32'd9;
    base = wr_cycles.size();
    apply_stimulus(5, 6, s);
    check_output("c_writes",   32'(wr_cycles.size() - base), 32'd0);
    check_output("c_error",    32'(error),                   32'd1);
    check_output("c_err_code", 32'(err_code),                32'd3);
    check_output("c_cols_kept", 32'(mat_cols),               32'd3);

    // 5x5 load, stray start mid-LOAD, then reset after the 10th write
    mem[0] = 32'd5; mem[1] = 32'd5;
    for (int k = 0; k < 25; k++) mem[2 + k] = 32'(k);
    base = wr_cycles.size();
    apply_stimulus(27, 7, s);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    rst_n = 1'b0;
    purge(cyc + 1);
    st_change[cyc + 1] = '0;
    plan_st = '0;
    @(negedge clk);
    check_output("e_writes", 32'(wr_cycles.size() - base), 32'd10);
    check_reset_values("e_reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Too few numbers, then a 1x1 matrix started right after the error
    mem[0] = 32'd1; mem[1] = 32'd1; mem[2] = 32'hFFFF_FFF9;
    apply_stimulus(1, 1, s);
    check_output("d_error",    32'(error),       32'd1);
    check_output("d_err_code", 32'(err_code),    32'd1);
    check_output("d_rd_addr",  32'(bus.rd_addr), 32'd0);
    @(negedge clk);
    check_output("d_rd_addr2", 32'(bus.rd_addr), 32'd0);
    base = wr_cycles.size();
    apply_stimulus(3, 6, s);
    check_output("f_writes",   32'(wr_cycles.size() - base), 32'd1);
    check_output("f_data",     wr_log[wr_log.size() - 1],    32'hFFFF_FFF9);
    check_output("f_done",     32'(done),                    32'd1);
    check_output("f_error",    32'(error),                   32'd0);
    check_output("f_err_code", 32'(err_code),                32'd0);
    check_output("f_rows",     32'(mat_rows),                32'd1);

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
